// File: rtl/twiddle_ram_writer.sv
// Twiddle-factor coefficient RAM: a streaming loader fills the whole table
// behind a valid/ready handshake, and the FFT engine reads it with 1-cycle latency.
module twiddle_ram_writer #(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clk_en,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic                  busy,
    output logic                  done,
    output logic                  table_valid,
    output logic [ADDR_WIDTH:0]   wr_count,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

    state_t                state, state_next;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic                  clear, accept, last;

    always_comb begin
        state_next = state;
        clear      = start && (state != DONE);
        // ready drops on a restart cycle so the discarded word is never handshaken
        s_ready    = rst && clk_en && (state == LOAD) && !start;
        accept     = s_ready && s_valid;
        last       = accept && (&wr_addr);
        busy       = (state == LOAD);
        done       = (state == DONE);
        case (state)
            IDLE:    if (start) state_next = LOAD;
            LOAD:    if (last)  state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            wr_addr     <= '0;
            wr_count    <= '0;
            table_valid <= 1'b0;
            rd_data     <= '0;
        end else if (clk_en) begin
            state   <= state_next;
            rd_data <= mem[rd_addr];
            if (clear) begin
                wr_addr     <= '0;
                wr_count    <= '0;
                table_valid <= 1'b0;
            end else if (accept) begin
                wr_addr  <= wr_addr + 1'b1;
                wr_count <= wr_count + 1'b1;
                if (last) table_valid <= 1'b1;
            end
        end
    end

    // No reset on the array: contents survive reset and aborted loads
    always_ff @(posedge clk) begin
        if (accept) mem[wr_addr] <= s_data;
    end

endmodule

// File: tb/tb_twiddle_ram_writer.sv
// Randomized scoreboard bench for twiddle_ram_writer: a transaction-level
// table model predicts handshakes, done pulses and read data.
module tb_twiddle_ram_writer;

    localparam int AW    = 9;
    localparam int DW    = 16;
    localparam int DEPTH = 2 ** AW;

    logic          clk, rst, clk_en, start, s_valid, s_ready, busy, done, table_valid;
    logic [DW-1:0] s_data, rd_data;
    logic [AW:0]   wr_count;
    logic [AW-1:0] rd_addr;

    twiddle_ram_writer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst), .clk_en(clk_en), .start(start),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .busy(busy), .done(done), .table_valid(table_valid),
        .wr_count(wr_count), .rd_addr(rd_addr), .rd_data(rd_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int tests  = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: table contents plus load progress
    logic [DW-1:0] model_mem [DEPTH];
    bit            m_loading = 0, m_done_due = 0, m_tv = 0;
    int            m_cnt = 0;
    bit            chk_on = 0, rd_pend = 0, done_prev = 0;
    int            obs_done = 0;
    logic [DW-1:0] rd_q[$];
    logic          rd_issue;

    // Monitor: outputs are stable at the falling edge
    always @(negedge clk) begin
        if (chk_on) begin
            if (rd_pend) begin
                if (rd_q.size() == 0) check("rd_q_underflow", 32'd1, 32'd0);
                else check("rd_data", rd_data, rd_q.pop_front());
            end
            check("s_ready", s_ready, m_loading && clk_en && !start && rst);
            check("busy", busy, m_loading);
            check("done", done, m_done_due);
            check("table_valid", table_valid, m_tv);
            check("wr_count", wr_count, m_cnt);
            if (done && !done_prev) obs_done++;
            done_prev = done;
        end
        rd_pend = rst && clk_en && rd_issue;
        if (!rst) begin
            m_loading = 0; m_done_due = 0; m_tv = 0; m_cnt = 0;
        end else if (clk_en) begin
            if (m_done_due) m_done_due = 0;
            else if (start) begin
                m_loading = 1; m_cnt = 0; m_tv = 0;
            end else if (m_loading && s_valid) begin
                model_mem[m_cnt] = s_data;
                m_cnt++;
                if (m_cnt == DEPTH) begin
                    m_loading = 0; m_done_due = 1; m_tv = 1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    function automatic logic [DW-1:0] pat(input int p, input int idx);
        logic [DW-1:0] a;
        a = DW'(idx);
        case (p)
            0:       return a ^ 16'hA5A5;
            1:       return DW'($urandom);
            2:       return a ^ 16'h5A5A;
            default: return DW'(idx * 3 + 7);
        endcase
    endfunction

    task automatic pulse_start(input bit with_word);
        start = 1; clk_en = 1; s_valid = with_word; s_data = 16'hDEAD;
        tick();
        start = 0; s_valid = 0;
    endtask

    // Present words until n are accepted; pv/pe are percent s_valid / clk_en
    task automatic load(input int n, input int p, input int pv, input int pe);
        int idx = 0, cyc = 0;
        logic [DW-1:0] d;
        d = pat(p, 0);
        while (idx < n && cyc < 8000) begin
            s_valid = ($urandom_range(99) < pv);
            clk_en  = ($urandom_range(99) < pe);
            s_data  = d;
            @(negedge clk);
            if (s_valid && s_ready) begin
                idx++;
                d = pat(p, idx);
            end
            tick();
            cyc++;
        end
        s_valid = 0; clk_en = 1;
        if (idx < n) check("load_timeout", idx, n);
    endtask

    task automatic sweep(input int lo, input int hi);
        clk_en = 1;
        for (int a = lo; a <= hi; a++) begin
            rd_addr = AW'(a); rd_issue = 1;
            rd_q.push_back(model_mem[a]);
            tick();
        end
        rd_issue = 0;
        tick(); tick();
        check("rd_q_drained", rd_q.size(), 0);
    endtask

    task automatic idle_cycles(input int n);
        clk_en = 1; s_valid = 0;
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        rst = 0; clk_en = 0; start = 0; s_valid = 0; s_data = '0; rd_addr = '0; rd_issue = 0;
        tick(); tick();
        chk_on = 1;
        check("reset_rd_data", rd_data, 0);
        rst = 1;
        idle_cycles(3);

        // Full load with fixed pattern, start during DONE ignored
        d0 = obs_done;
        pulse_start(0);
        load(DEPTH, 0, 100, 100);
        start = 1; tick(); start = 0;
        idle_cycles(2);
        check("full_done_once", obs_done - d0, 1);
        check("full_wr_count", wr_count, DEPTH);
        check("full_table_valid", table_valid, 1);
        check("full_busy", busy, 0);
        sweep(0, DEPTH - 1);

        // Random valid/enable gaps; start in IDLE with table_valid=1
        d0 = obs_done;
        pulse_start(0);
        load(DEPTH, 1, 50, 80);
        idle_cycles(3);
        check("rand_done_once", obs_done - d0, 1);
        sweep(0, DEPTH - 1);

        // Restart after word 100, word offered on restart cycle is dropped
        d0 = obs_done;
        pulse_start(0);
        load(101, 3, 100, 100);
        check("pre_restart_done", obs_done - d0, 0);
        pulse_start(1);
        check("restart_wr_count", wr_count, 0);
        load(DEPTH, 2, 100, 100);
        idle_cycles(2);
        check("restart_done_once", obs_done - d0, 1);
        sweep(0, DEPTH - 1);

        // Reset mid-load at word 200
        pulse_start(0);
        load(200, 3, 100, 100);
        rst = 0; tick(); rst = 1;
        check("rst_rd_data", rd_data, 0);
        check("rst_wr_count", wr_count, 0);
        check("rst_table_valid", table_valid, 0);
        idle_cycles(2);
        sweep(0, 199);

        // Read-during-write at address 5, then finish the load
        d0 = obs_done;
        pulse_start(0);
        load(5, 0, 100, 100);
        rd_addr = 5; rd_issue = 1; rd_q.push_back(model_mem[5]);
        s_valid = 1; s_data = 16'h1234;
        tick();
        s_valid = 0;
        rd_q.push_back(model_mem[5]);
        tick();
        rd_issue = 0;
        tick();
        check("rdw_new_value", model_mem[5], 16'h1234);
        load(DEPTH - 6, 1, 70, 90);
        idle_cycles(3);
        check("rdw_done_once", obs_done - d0, 1);
        sweep(0, 15);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
